// File: rtl/load_pkg.sv
// Shared load-unit types: RISC-V load funct3 codes, decoded load type, FSM states.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    LT_LB, LT_LH, LT_LW, LT_LD, LT_LBU, LT_LHU, LT_LWU
  } loadtype_e;

  typedef enum logic [1:0] {
    S_IDLE, S_RD0, S_RD1, S_RESP
  } state_e;

  function automatic logic [3:0] lt_bytes(input loadtype_e lt);
    case (lt)
      LT_LB, LT_LBU: return 4'd1;
      LT_LH, LT_LHU: return 4'd2;
      LT_LW, LT_LWU: return 4'd4;
      default:       return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational little-endian byte extraction and sign/zero extension of a
// load result from a pair of memory words (low word first).
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] word_lo,
  input  logic [XLEN-1:0] word_hi,
  input  logic [OFFW-1:0] offset,
  input  loadtype_e       ltype,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] win;

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    // Shifting the concatenated pair lets a split access pick up its high
    // bytes from the second word with no extra muxing.
    win  = XLEN'({word_hi, word_lo} >> {offset, 3'b000});
    data = '0;
    case (ltype)
      LT_LB:   data = sext8(win[7:0]);
      LT_LH:   data = sext16(win[15:0]);
      LT_LW:   data = sext32(win[31:0]);
      LT_LBU:  data = XLEN'(win[7:0]);
      LT_LHU:  data = XLEN'(win[15:0]);
      LT_LWU:  data = XLEN'(win[31:0]);
      LT_LD:   data = win;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RISC-V load unit: decode, word-aligned memory read(s), extraction.
// Define LOAD_MISALIGNED_SPLIT_EN to service word-crossing loads with a second read.
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_misaligned,
  output logic              rsp_illegal
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_e            state, state_nx;
  loadtype_e         dec_ltype, ltype_q;
  logic              dec_legal, dec_mis, accept, split;
  logic              illegal_q, misal_q;
  logic [ADDR_W-1:0] addr_q, addr_al;
  logic [XLEN-1:0]   word0_q, word_hi, ext_data;

  always_comb begin
    dec_ltype = LT_LB;
    dec_legal = 1'b1;
    case (req_funct3)
      F3_LB:   dec_ltype = LT_LB;
      F3_LH:   dec_ltype = LT_LH;
      F3_LW:   dec_ltype = LT_LW;
      F3_LBU:  dec_ltype = LT_LBU;
      F3_LHU:  dec_ltype = LT_LHU;
      F3_LD:   begin dec_ltype = LT_LD;  dec_legal = (XLEN == 64); end
      F3_LWU:  begin dec_ltype = LT_LWU; dec_legal = (XLEN == 64); end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept  = req_valid && (state == S_IDLE);
  assign addr_al = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

`ifdef LOAD_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0] word1_q;
  logic [4:0]      end_b;

  assign dec_mis = 1'b0;
  assign end_b   = 5'(addr_q[OFFW-1:0]) + 5'(lt_bytes(ltype_q));
  assign split   = end_b > 5'(NB);
  assign word_hi = word1_q;

  always_ff @(posedge clk) begin
    if (state == S_RD1 && mem_rvalid) word1_q <= mem_rdata;
  end
`else
  // Natural alignment: the offset must be a multiple of the access size.
  assign dec_mis = |(req_addr[OFFW-1:0] & OFFW'(lt_bytes(dec_ltype) - 4'd1));
  assign split   = 1'b0;
  assign word_hi = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
      misal_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        illegal_q <= !dec_legal;
        misal_q   <= dec_legal && dec_mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ltype_q <= dec_ltype;
      addr_q  <= req_addr;
    end
    if (state == S_RD0 && mem_rvalid) word0_q <= mem_rdata;
  end

  load_extract #(.XLEN(XLEN), .OFFW(OFFW)) u_extract (
    .word_lo (word0_q),
    .word_hi (word_hi),
    .offset  (addr_q[OFFW-1:0]),
    .ltype   (ltype_q),
    .data    (ext_data)
  );

  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = '0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_misaligned = 1'b0;
    rsp_illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = (!dec_legal || dec_mis) ? S_RESP : S_RD0;
      end
      S_RD0: begin
        mem_re   = 1'b1;
        mem_addr = addr_al;
        if (mem_rvalid) state_nx = split ? S_RD1 : S_RESP;
      end
`ifdef LOAD_MISALIGNED_SPLIT_EN
      S_RD1: begin
        mem_re   = 1'b1;
        mem_addr = addr_al + ADDR_W'(NB);
        if (mem_rvalid) state_nx = S_RESP;
      end
`endif
      S_RESP: begin
        rsp_valid      = 1'b1;
        rsp_misaligned = misal_q;
        rsp_illegal    = illegal_q;
        rsp_data       = (illegal_q || misal_q) ? '0 : ext_data;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed table-driven bench for load_unit at XLEN=32 and XLEN=64.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rv32 = 1'b0, rv64 = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0;
  logic        mrv = 1'b0;
  logic [63:0] mrd = '0;
  bit          wide = 1'b0;

  logic        rdy32, re32, v32, mis32, ill32;
  logic [31:0] ma32, d32;
  logic        rdy64, re64, v64, mis64, ill64;
  logic [31:0] ma64;
  logic [63:0] d64;

  logic        rdy, re, vld, mis, ill;
  logic [31:0] ma;
  logic [63:0] dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_valid(rv32), .req_ready(rdy32),
    .req_funct3(f3), .req_addr(addr), .mem_re(re32), .mem_addr(ma32),
    .mem_rvalid(mrv), .mem_rdata(mrd[31:0]), .rsp_valid(v32), .rsp_data(d32),
    .rsp_misaligned(mis32), .rsp_illegal(ill32)
  );

  load_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .req_valid(rv64), .req_ready(rdy64),
    .req_funct3(f3), .req_addr(addr), .mem_re(re64), .mem_addr(ma64),
    .mem_rvalid(mrv), .mem_rdata(mrd), .rsp_valid(v64), .rsp_data(d64),
    .rsp_misaligned(mis64), .rsp_illegal(ill64)
  );

  assign rdy = wide ? rdy64 : rdy32;
  assign re  = wide ? re64  : re32;
  assign vld = wide ? v64   : v32;
  assign mis = wide ? mis64 : mis32;
  assign ill = wide ? ill64 : ill32;
  assign ma  = wide ? ma64  : ma32;
  assign dat = wide ? d64   : {32'h0, d32};

  typedef struct {
    string       name;
    bit          w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] w0, w1, data;
    bit          mis, ill;
    int          lat, nacc;
    logic [31:0] a0, a1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input bit w, input logic [2:0] f,
                              input logic [31:0] a, input logic [63:0] w0, w1, data,
                              input bit m, il, input int lat, nacc,
                              input logic [31:0] a0, a1);
    vec_t v;
    v.name = name; v.w = w; v.f3 = f; v.addr = a; v.w0 = w0; v.w1 = w1;
    v.data = data; v.mis = m; v.ill = il; v.lat = lat; v.nacc = nacc;
    v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          acc, lat;
    logic [31:0] ga0, ga1;
    logic [63:0] gd;
    logic        gm, gi;
    acc = 0; lat = -1; ga0 = '0; ga1 = '0; gd = '0; gm = 1'b0; gi = 1'b0;
    @(negedge clk);
    wide = v.w; f3 = v.f3; addr = v.addr;
    rv32 = !v.w; rv64 = v.w;
    #1 chk({v.name, ".ready"}, rdy, 1);
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      rv32 = 1'b0; rv64 = 1'b0; mrv = 1'b0;
      if (vld) begin
        lat = c; gd = dat; gm = mis; gi = ill;
      end else if (re) begin
        if (acc == 0) ga0 = ma; else ga1 = ma;
        mrd = (acc == 0) ? v.w0 : v.w1;
        mrv = 1'b1;
        acc++;
      end
    end
    chk({v.name, ".lat"}, 64'(lat), 64'(v.lat));
    chk({v.name, ".data"}, gd, v.data);
    chk({v.name, ".mis"}, 64'(gm), 64'(v.mis));
    chk({v.name, ".ill"}, 64'(gi), 64'(v.ill));
    chk({v.name, ".nacc"}, 64'(acc), 64'(v.nacc));
    if (v.nacc >= 1) chk({v.name, ".a0"}, 64'(ga0), 64'(v.a0));
    if (v.nacc >= 2) chk({v.name, ".a1"}, 64'(ga1), 64'(v.a1));
    @(negedge clk);
    chk({v.name, ".pulse"}, 64'(vld), 0);
    chk({v.name, ".idledata"}, dat, 0);
    chk({v.name, ".idleready"}, 64'(rdy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // XLEN=32 vectors common to both builds
    tbl.push_back(mk("lb_1003",  0, 3'b000, 32'h1003, 64'h80FF1234, 0, 64'hFFFFFF80, 0, 0, 2, 1, 32'h1000, 0));
    tbl.push_back(mk("lhu_2002", 0, 3'b101, 32'h2002, 64'hBEEF0000, 0, 64'h0000BEEF, 0, 0, 2, 1, 32'h2000, 0));
    tbl.push_back(mk("lbu_1003", 0, 3'b100, 32'h1003, 64'h80FF1234, 0, 64'h00000080, 0, 0, 2, 1, 32'h1000, 0));
    tbl.push_back(mk("lh_0",     0, 3'b001, 32'h0000, 64'h00018765, 0, 64'hFFFF8765, 0, 0, 2, 1, 32'h0000, 0));
    tbl.push_back(mk("lw_10",    0, 3'b010, 32'h0010, 64'h12345678, 0, 64'h12345678, 0, 0, 2, 1, 32'h0010, 0));
    tbl.push_back(mk("lb_1",     0, 3'b000, 32'h0001, 64'h00007F00, 0, 64'h0000007F, 0, 0, 2, 1, 32'h0000, 0));
    tbl.push_back(mk("ill_011",  0, 3'b011, 32'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk("ill_110",  0, 3'b110, 32'h0004, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk("ill_111",  0, 3'b111, 32'h0004, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    // XLEN=64 vectors common to both builds
    tbl.push_back(mk("lwu64_8",  1, 3'b110, 32'h0008, 64'h00000000_F0000000, 0, 64'h00000000F0000000, 0, 0, 2, 1, 32'h8, 0));
    tbl.push_back(mk("ld64_10",  1, 3'b011, 32'h0010, 64'h88776655_44332211, 0, 64'h8877665544332211, 0, 0, 2, 1, 32'h10, 0));
    tbl.push_back(mk("lw64_c",   1, 3'b010, 32'h000C, 64'h80000000_00000000, 0, 64'hFFFFFFFF80000000, 0, 0, 2, 1, 32'h8, 0));
    tbl.push_back(mk("lb64_17",  1, 3'b000, 32'h0017, 64'hFE000000_00000000, 0, 64'hFFFFFFFFFFFFFFFE, 0, 0, 2, 1, 32'h10, 0));
    tbl.push_back(mk("lwu64_4",  1, 3'b110, 32'h0004, 64'h89ABCDEF_00000000, 0, 64'h0000000089ABCDEF, 0, 0, 2, 1, 32'h0, 0));
    tbl.push_back(mk("ill64_111",1, 3'b111, 32'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0));
`ifdef LOAD_MISALIGNED_SPLIT_EN
    tbl.push_back(mk("lw_3002",  0, 3'b010, 32'h3002, 64'hDDCCBBAA, 64'h44332211, 64'h2211DDCC, 0, 0, 3, 2, 32'h3000, 32'h3004));
    tbl.push_back(mk("lh_3003",  0, 3'b001, 32'h3003, 64'hDDCCBBAA, 64'h44332211, 64'h000011DD, 0, 0, 3, 2, 32'h3000, 32'h3004));
    tbl.push_back(mk("lhu_1",    0, 3'b101, 32'h0001, 64'hDDCCBBAA, 0, 64'h0000CCBB, 0, 0, 2, 1, 32'h0000, 0));
    tbl.push_back(mk("lw_wrap",  0, 3'b010, 32'hFFFFFFFE, 64'h11223344, 64'h55667788, 64'h77881122, 0, 0, 3, 2, 32'hFFFFFFFC, 32'h0));
    tbl.push_back(mk("ld64_4",   1, 3'b011, 32'h0004, 64'h44332211_00000000, 64'h00000000_88776655, 64'h8877665544332211, 0, 0, 3, 2, 32'h0, 32'h8));
`else
    tbl.push_back(mk("lw_3002",  0, 3'b010, 32'h3002, 64'hDDCCBBAA, 64'h44332211, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("lh_3003",  0, 3'b001, 32'h3003, 64'hDDCCBBAA, 64'h44332211, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("lhu_1",    0, 3'b101, 32'h0001, 64'hDDCCBBAA, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("lw_wrap",  0, 3'b010, 32'hFFFFFFFE, 64'h11223344, 64'h55667788, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ld64_4",   1, 3'b011, 32'h0004, 64'h44332211_00000000, 64'h00000000_88776655, 0, 1, 0, 1, 0, 0, 0));
`endif

    // reset state
    #2;
    chk("rst.ready32", 64'(rdy32), 1);
    chk("rst.re32", 64'(re32), 0);
    chk("rst.addr32", 64'(ma32), 0);
    chk("rst.valid32", 64'(v32), 0);
    chk("rst.data32", 64'(d32), 0);
    chk("rst.flags32", 64'({mis32, ill32}), 0);
    chk("rst.ready64", 64'(rdy64), 1);
    chk("rst.re64", 64'(re64), 0);
    chk("rst.data64", d64, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // rvalid while idle must not produce anything
    mrv = 1'b1; mrd = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rvalid.v32", 64'(v32), 0);
      chk("idle_rvalid.v64", 64'(v64), 0);
      chk("idle_rvalid.rdy32", 64'(rdy32), 1);
    end
    mrv = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // stall in RD0 for 5 cycles
    wide = 1'b0;
    @(negedge clk);
    f3 = 3'b010; addr = 32'h40; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.re", 64'(re32), 1);
      chk("stall.addr", 64'(ma32), 64'h40);
      chk("stall.valid", 64'(v32), 0);
      chk("stall.ready", 64'(rdy32), 0);
      @(negedge clk);
    end
    mrv = 1'b1; mrd = 64'hCAFEF00D;
    @(negedge clk);
    mrv = 1'b0;
    chk("stall.rsp", 64'(v32), 1);
    chk("stall.data", 64'(d32), 64'hCAFEF00D);
    @(negedge clk);

    // reset during an outstanding read
    @(negedge clk);
`ifdef LOAD_MISALIGNED_SPLIT_EN
    f3 = 3'b010; addr = 32'h3002; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0; mrv = 1'b1; mrd = 64'hDDCCBBAA;
    @(negedge clk);
    mrv = 1'b0;
    chk("rd1.re", 64'(re32), 1);
    chk("rd1.addr", 64'(ma32), 64'h3004);
`else
    f3 = 3'b010; addr = 32'h44; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    chk("rd0.re", 64'(re32), 1);
    chk("rd0.addr", 64'(ma32), 64'h44);
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.ready", 64'(rdy32), 1);
    chk("midrst.re", 64'(re32), 0);
    chk("midrst.addr", 64'(ma32), 0);
    chk("midrst.valid", 64'(v32), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mrv = 1'b1; mrd = 64'h44332211;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid.valid", 64'(v32), 0);
      chk("late_rvalid.re", 64'(re32), 0);
      chk("late_rvalid.ready", 64'(rdy32), 1);
    end
    mrv = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64 only.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  Reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  Load request present.
REQ-006 req_ready  output  1  Unit can accept a request; high only in IDLE.
REQ-007 req_funct3  input  3  RISC-V load funct3.
REQ-008 req_addr  input  ADDR_W  Byte address of the load.
REQ-009 mem_re  output  1  Memory read strobe.
REQ-010 mem_addr  output  ADDR_W  Access address, aligned to XLEN/8 bytes.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle; may be high in the same cycle mem_re rises.
REQ-012 mem_rdata  input  XLEN  Memory read word.
REQ-013 rsp_valid  output  1  One-cycle response pulse.
REQ-014 rsp_data  output  XLEN  Extracted, extended load result.
REQ-015 rsp_misaligned  output  1  Misaligned-access exception, qualified by rsp_valid.
REQ-016 rsp_illegal  output  1  Illegal-funct3 exception, qualified by rsp_valid.

Function
REQ-017 funct3 decode: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011 ld and 110 lwu legal only when XLEN=64; all other codes, and 011/110 at XLEN=32, are illegal.
REQ-018 States: IDLE, RD0, RD1, RESP.
REQ-019 IDLE: req_valid&&req_ready captures funct3 and addr. Illegal code -> RESP with rsp_illegal=1 and no memory access. Otherwise -> RD0.
REQ-020 RD0: mem_re=1, mem_addr = captured addr with low log2(XLEN/8) bits cleared; state and outputs held until mem_rvalid.
REQ-021 RD0 on mem_rvalid: word latched; access contained in the word -> RESP; access crossing the word boundary -> RD1.
REQ-022 RD1: mem_re=1, mem_addr = aligned addr + XLEN/8 (wraps modulo 2^ADDR_W); on mem_rvalid, second word latched -> RESP.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 during RESP.
REQ-024 Byte extraction is little-endian; a split access takes its low bytes from the RD0 word and its high bytes from the RD1 word.
REQ-025 lb/lh/lw sign-extend to XLEN; lbu/lhu/lwu zero-extend; ld passes through.
REQ-026 Latency, zero-wait memory: accept in cycle 0, RD0 in cycle 1, rsp_valid in cycle 2; split access: rsp_valid in cycle 3; illegal: rsp_valid in cycle 1.
REQ-027 mem_rvalid outside RD0/RD1 is ignored.
REQ-028 rsp_data is 0 and both flags are 0 whenever rsp_valid=0.

Reset
REQ-029 reset_n low forces IDLE asynchronously, at any state including mid-RD0/RD1; req_ready=1, mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, both flags 0.
REQ-030 No request or response survives reset; a late mem_rvalid after reset is ignored (REQ-027).

Configuration
REQ-031 Macro LOAD_MISALIGNED_SPLIT_EN defined: boundary-crossing loads use the RD1 second access (REQ-021/022).
REQ-032 Macro undefined: RD1 does not exist; a misaligned legal load goes IDLE -> RESP with rsp_misaligned=1, rsp_data=0, and no mem_re.
REQ-033 Without the macro, misalignment is the address not being a multiple of the access size; naturally aligned loads behave identically under both builds.

Structure
REQ-034 Package load_pkg holds funct3 constants, the loadtype enum (lb, lh, lw, ld, lbu, lhu, lwu), and the state enum.
REQ-035 Sub-module load_extract is purely combinational: (words, byte offset, loadtype) -> rsp_data; all sequencing stays in load_unit.

Verification
REQ-036 XLEN=32, lb @0x1003, word 0x80FF1234 -> rsp_data 0xFFFFFF80, rsp_valid in cycle 2.
REQ-037 XLEN=32, lhu @0x2002, word 0xBEEF0000 -> rsp_data 0x0000BEEF.
REQ-038 Macro on, lw @0x3002, words 0xDDCCBBAA @0x3000 and 0x44332211 @0x3004 -> mem_addr 0x3000 then 0x3004, rsp_data 0x2211DDCC, rsp_valid in cycle 3; macro off -> rsp_misaligned=1 in cycle 1, mem_re never high.
REQ-039 XLEN=32, funct3=011 -> rsp_illegal=1 in cycle 1, no mem_re; XLEN=64, lwu @0x8, dword 0x00000000_F0000000 -> 0x00000000F0000000.
REQ-040 Hold mem_rvalid low for 5 cycles in RD0 -> mem_re and mem_addr stable, no rsp_valid; assert reset_n low in RD1 -> immediate IDLE, req_ready=1, mem_re=0, a following mem_rvalid produces no response.
